// File: rtl/e1_pkg.sv
// Shared types for the E1 token link: token codes, the reserved illegal code,
// and the serializer frame states.
package e1_pkg;

  typedef logic [1:0] E1;

  localparam E1 E1_FIRST   = 2'b01;
  localparam E1 E1_SECOND  = 2'b10;
  localparam E1 E1_THIRD   = 2'b11;
  localparam E1 E1_ILLEGAL = 2'b00;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA0 = 3'd2;
  localparam logic [2:0] ST_DATA1 = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  function automatic logic e1IsLegal(input E1 code);
    return code != E1_ILLEGAL;
  endfunction

endpackage

// File: rtl/e1_serial_tx_if.sv
// Valid/ready token channel between an E1 producer and the serial transmitter.
interface e1_serial_tx_if;
  import e1_pkg::*;

  E1    in_data;
  logic in_valid;
  logic in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/e1_fifo.sv
// Synchronous token FIFO; pointers carry an extra wrap bit to tell full from empty.
module e1_fifo
  import e1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  E1    i_data,
  output E1    o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  E1              r_mem [DEPTH];
  logic [AW:0]    r_wrPtr;
  logic [AW:0]    r_rdPtr;
  logic           w_doPush;
  logic           w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_data   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/e1_serial_tx.sv
// E1 token transmitter: buffers accepted tokens and sends each as
// start, two data bits LSB first, and stop on an idle-high line.
module e1_serial_tx
  import e1_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  e1_serial_tx_if.slave    bus,
  output logic             ser_out,
  output logic             busy,
  output logic             err_illegal,
  output logic [CNT_W-1:0] tx_count
);

  localparam int CNT_BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_BW-1:0] CNT_RELOAD = CNT_BW'(CLKS_PER_BIT - 1);

  logic [2:0]        r_state;
  logic [CNT_BW-1:0] r_cnt;
  E1                 r_shift;
  logic              r_ser;
  logic              r_err;
  logic [CNT_W-1:0]  r_txCount;

  logic w_full;
  logic w_empty;
  E1    w_head;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_bitDone;

  assign bus.in_ready = ~w_full;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_push       = w_accept && e1IsLegal(bus.in_data);
  assign w_bitDone    = (r_cnt == '0);

  // A token leaves the FIFO either from idle or on the final STOP cycle,
  // which is what makes back-to-back frames contiguous.
  always_comb begin
    w_pop = 1'b0;
    if (!w_empty) begin
      if (r_state == ST_IDLE) w_pop = 1'b1;
      else if (r_state == ST_STOP && w_bitDone) w_pop = 1'b1;
    end
  end

  e1_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.in_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shift   <= E1_ILLEGAL;
      r_ser     <= 1'b1;
      r_err     <= 1'b0;
      r_txCount <= '0;
    end else begin
      r_err <= w_accept && !e1IsLegal(bus.in_data);
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_START;
            r_cnt   <= CNT_RELOAD;
            r_shift <= w_head;
            r_ser   <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bitDone) begin
            r_state <= ST_DATA0;
            r_cnt   <= CNT_RELOAD;
            r_ser   <= r_shift[0];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DATA0: begin
          if (w_bitDone) begin
            r_state <= ST_DATA1;
            r_cnt   <= CNT_RELOAD;
            r_ser   <= r_shift[1];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DATA1: begin
          if (w_bitDone) begin
            r_state <= ST_STOP;
            r_cnt   <= CNT_RELOAD;
            r_ser   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bitDone) begin
            r_txCount <= r_txCount + 1'b1;
            r_cnt     <= CNT_RELOAD;
            if (w_pop) begin
              r_state <= ST_START;
              r_shift <= w_head;
              r_ser   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_ser   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ser   <= 1'b1;
        end
      endcase
    end
  end

  assign ser_out     = r_ser;
  assign err_illegal = r_err;
  assign tx_count    = r_txCount;
  assign busy        = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_e1_serial_tx.sv
// Directed bench for e1_serial_tx: vector table of tokens and line patterns,
// plus hand-written sequences for bursts, illegal codes, reset abort and counter wrap.
module tb_e1_serial_tx;
  import e1_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  e1_serial_tx_if busA ();
  e1_serial_tx_if busB ();

  logic       serA, busyA, errA;
  logic [7:0] cntA;
  logic       serB, busyB, errB;
  logic [1:0] cntB;

  e1_serial_tx #(.FIFO_DEPTH(4), .CLKS_PER_BIT(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (busA),
    .ser_out     (serA),
    .busy        (busyA),
    .err_illegal (errA),
    .tx_count    (cntA)
  );

  e1_serial_tx #(.FIFO_DEPTH(4), .CLKS_PER_BIT(4), .CNT_W(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (busB),
    .ser_out     (serB),
    .busy        (busyB),
    .err_illegal (errB),
    .tx_count    (cntB)
  );

  // pattern holds {start, d0, d1, stop} with start in bit 3
  typedef struct {
    E1          tok;
    logic [3:0] pattern;
  } vec_t;

  vec_t       vecs [6];
  logic [1:0] wrapExp [5];
  int         nErrors = 0;
  int         nChecks = 0;
  logic       sawFull;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers one token on busA starting at a negedge; returns on the negedge after the transfer.
  task automatic applyStimulus(input E1 tok);
    busA.in_data  = tok;
    busA.in_valid = 1'b1;
    for (int i = 0; i < 200 && !busA.in_ready; i++) @(negedge clk);
    if (!busA.in_ready) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL pushTimeout: in_ready got 0 expected 1");
    end
    @(negedge clk);
    busA.in_valid = 1'b0;
  endtask

  // Waits for the start bit, then checks every line cycle of n contiguous frames.
  task automatic checkFrames(input int first, input int n, input string name);
    int f, b;
    for (int i = 0; i < 40 && serA !== 1'b0; i++) @(negedge clk);
    checkOutput({name, "StartSeen"}, serA, 1'b0);
    for (int c = 0; c < n * 16; c++) begin
      f = first + c / 16;
      b = (c % 16) / 4;
      checkOutput($sformatf("%sLine_f%0d_c%0d", name, f, c), serA, vecs[f].pattern[3-b]);
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{E1_FIRST,  4'b0101};
    vecs[1] = '{E1_SECOND, 4'b0011};
    vecs[2] = '{E1_THIRD,  4'b0111};
    vecs[3] = '{E1_FIRST,  4'b0101};
    vecs[4] = '{E1_SECOND, 4'b0011};
    vecs[5] = '{E1_THIRD,  4'b0111};
    wrapExp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst_n         = 1'b0;
    busA.in_data  = E1_ILLEGAL;
    busA.in_valid = 1'b0;
    busB.in_data  = E1_ILLEGAL;
    busB.in_valid = 1'b0;
    sawFull       = 1'b0;

    // Reset values and a quiet idle line
    @(negedge clk);
    @(negedge clk);
    checkOutput("resetSer",   serA, 1'b1);
    checkOutput("resetReady", busA.in_ready, 1'b1);
    checkOutput("resetBusy",  busyA, 1'b0);
    checkOutput("resetErr",   errA, 1'b0);
    checkOutput("resetCount", cntA, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_%0d", i), {serA, busyA, busA.in_ready, cntA}, {1'b1, 1'b0, 1'b1, 8'd0});
    end

    // Single token: start bit exactly one edge after the accept edge
    applyStimulus(vecs[1].tok);
    checkOutput("singleNotEarly", serA, 1'b1);
    checkOutput("singleBusy", busyA, 1'b1);
    @(negedge clk);
    checkOutput("singleStartLatency", serA, 1'b0);
    checkFrames(1, 1, "single");
    checkOutput("singleCount", cntA, 8'd1);
    checkOutput("singleIdleBusy", busyA, 1'b0);
    checkOutput("singleIdleSer", serA, 1'b1);

    // Burst of six with valid held: FIFO fills, frames run back to back
    doReset();
    checkOutput("burstPreCount", cntA, 8'd0);
    fork
      begin
        for (int k = 0; k < 6; k++) applyStimulus(vecs[k].tok);
      end
      checkFrames(0, 6, "burst");
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (!busA.in_ready) sawFull = 1'b1;
        end
      end
    join
    checkOutput("burstReadyDrop", sawFull, 1'b1);
    checkOutput("burstCount", cntA, 8'd6);
    checkOutput("burstBusyDone", busyA, 1'b0);
    checkOutput("burstReadyDone", busA.in_ready, 1'b1);

    // Illegal code: accepted, flagged for one cycle, never transmitted
    busA.in_data  = E1_ILLEGAL;
    busA.in_valid = 1'b1;
    checkOutput("illegalReady", busA.in_ready, 1'b1);
    @(negedge clk);
    busA.in_valid = 1'b0;
    checkOutput("illegalErrPulse", errA, 1'b1);
    checkOutput("illegalNotQueued", busyA, 1'b0);
    @(negedge clk);
    checkOutput("illegalErrCleared", errA, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (serA !== 1'b1 || busyA !== 1'b0 || errA !== 1'b0) bad++;
      @(negedge clk);
    end
    checkOutput("illegalNoFrame", bad, 0);
    checkOutput("illegalCount", cntA, 8'd6);

    // Reset during DATA0 of a third-token frame with two tokens still queued
    applyStimulus(E1_THIRD);
    applyStimulus(E1_FIRST);
    applyStimulus(E1_SECOND);
    repeat (4) @(negedge clk);
    checkOutput("abortInData0", serA, 1'b1);
    checkOutput("abortBusyBefore", busyA, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("abortSer", serA, 1'b1);
    checkOutput("abortReady", busA.in_ready, 1'b1);
    checkOutput("abortBusy", busyA, 1'b0);
    checkOutput("abortCount", cntA, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (serA !== 1'b1 || busyA !== 1'b0) bad++;
    end
    checkOutput("abortNoStale", bad, 0);
    checkOutput("abortCountStays", cntA, 8'd0);

    // Narrow counter wraps: 1,2,3,0,1
    for (int k = 0; k < 5; k++) begin
      busB.in_data  = vecs[k].tok;
      busB.in_valid = 1'b1;
      @(negedge clk);
      busB.in_valid = 1'b0;
      for (int i = 0; i < 40 && busyB; i++) @(negedge clk);
      checkOutput($sformatf("wrapCount_%0d", k), cntB, wrapExp[k]);
    end
    checkOutput("wrapErr", errB, 1'b0);
    checkOutput("wrapSerIdle", serB, 1'b1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
